// File: rtl/fifo_pack_pkg.sv
// fifo_pack_pkg: default geometry, reset values and width helpers shared by the
// word packer, its checker and the FIFO bench.
package fifo_pack_pkg;

  localparam int PACK_DW_DEFAULT = 8;
  localparam int PACK_N_DEFAULT  = 4;

  localparam logic PACK_RST_REQ = 1'b0;
  localparam logic PACK_RST_ACK = 1'b0;

  // Width able to hold a fill count of 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  typedef logic [$clog2(PACK_N_DEFAULT)-1:0] lane_idx_t;

endpackage

// File: rtl/fifo_word_packer_chk.sv
// fifo_word_packer_chk: protocol properties of the packer's output port and of
// ack_in during reset; bound to the packer ports by the instantiating bench.
module fifo_word_packer_chk
  import fifo_pack_pkg::*;
#(
  parameter int DW = PACK_DW_DEFAULT,
  parameter int N  = PACK_N_DEFAULT,
  localparam int CW = cnt_width(N)
) (
  input logic          clk,
  input logic          rst,
  input logic          req_in,
  input logic          ack_in,
  input logic [DW*N-1:0] d_out,
  input logic [CW-1:0] cnt_out,
  input logic          req_out,
  input logic          ack_out
);

  a_no_ack_in_reset: assert property (@(posedge clk) rst |-> (ack_in == PACK_RST_ACK))
    else $error("checker: ack_in high during reset");

  a_hold: assert property (@(posedge clk) disable iff (rst)
    (req_out && !ack_out) |=> (req_out && $stable(d_out) && $stable(cnt_out)))
    else $error("checker: held word changed or dropped while stalled");

  a_rise_after_accept: assert property (@(posedge clk) disable iff (rst)
    $rose(req_out) |-> $past(req_in && ack_in))
    else $error("checker: req_out rose without an accepted beat");

`ifdef FIFO_PACK_FLUSH_EN
  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    req_out |-> ((cnt_out >= CW'(1'b1)) && (cnt_out <= CW'(N))))
    else $error("checker: cnt_out out of range");
`else
  a_cnt_full: assert property (@(posedge clk) disable iff (rst)
    req_out |-> (cnt_out == CW'(N)))
    else $error("checker: cnt_out not a full word");
`endif

endmodule

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: packs N DW-bit FIFO beats into one DW*N-bit word, holding one
// finished word while the next assembles. Early close via last_in when FIFO_PACK_FLUSH_EN is defined.
module fifo_word_packer
  import fifo_pack_pkg::*;
#(
  parameter int DW = PACK_DW_DEFAULT,
  parameter int N  = PACK_N_DEFAULT,
  localparam int CW = cnt_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   d_in,
  input  logic            req_in,
`ifdef FIFO_PACK_FLUSH_EN
  input  logic            last_in,
`endif
  output logic            ack_in,
  output logic [DW*N-1:0] d_out,
  output logic [CW-1:0]   cnt_out,
  output logic            req_out,
  input  logic            ack_out
);

  localparam int LW = $clog2(N);
  localparam logic [LW-1:0] LAST_LANE = LW'(N - 1);

  logic [DW*N-1:0] r_acc;
  logic [LW-1:0]   r_cnt;
  logic [DW*N-1:0] r_dout;
  logic [CW-1:0]   r_cnt_out;
  logic            r_req;

  logic            w_last;
  logic            w_closing;
  logic            w_ack_in;
  logic            w_accept;
  logic            w_xfer;
  logic [DW*N-1:0] w_word;
  logic [CW-1:0]   w_fill;

`ifdef FIFO_PACK_FLUSH_EN
  assign w_last = last_in;
`else
  assign w_last = 1'b0;
`endif

  assign w_closing = (r_cnt == LAST_LANE) || w_last;
  // A closing beat may only enter when the holding register is free or empties this cycle.
  assign w_ack_in  = ~rst & (~w_closing | ~r_req | ack_out);
  assign w_accept  = req_in & w_ack_in;
  assign w_xfer    = r_req & ack_out;
  assign w_fill    = CW'(r_cnt) + CW'(1'b1);

  // Current beat merged into its lane; lanes above the fill point forced to zero.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < N; i++) begin
      if (LW'(i) == r_cnt) begin
        w_word[i*DW +: DW] = d_in;
      end else if (LW'(i) < r_cnt) begin
        w_word[i*DW +: DW] = r_acc[i*DW +: DW];
      end else begin
        w_word[i*DW +: DW] = '0;
      end
    end
  end

  // Accumulator and lane counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_closing) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_word;
        r_cnt <= r_cnt + LW'(1'b1);
      end
    end
  end

  // Output holding register; a closing beat reloads it even while the old word leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout    <= '0;
      r_cnt_out <= '0;
      r_req     <= PACK_RST_REQ;
    end else if (w_accept && w_closing) begin
      r_dout    <= w_word;
      r_cnt_out <= w_fill;
      r_req     <= 1'b1;
    end else if (w_xfer) begin
      r_req     <= 1'b0;
    end
  end

  assign ack_in  = w_ack_in;
  assign d_out   = r_dout;
  assign cnt_out = r_cnt_out;
  assign req_out = r_req;

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: directed and randomised checks of fifo_word_packer (DW=8, N=4);
// the early-close scenario is included when FIFO_PACK_FLUSH_EN is defined.
module tb_fifo_word_packer;
  import fifo_pack_pkg::*;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int CW = 3;

  logic            clk     = 1'b0;
  logic            rst     = 1'b0;
  logic [DW-1:0]   d_in    = '0;
  logic            req_in  = 1'b0;
  logic            ack_out = 1'b0;
  logic            ack_in;
  logic [DW*N-1:0] d_out;
  logic [CW-1:0]   cnt_out;
  logic            req_out;
`ifdef FIFO_PACK_FLUSH_EN
  logic            last_in = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_word_packer #(.DW(DW), .N(N)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .d_in    (d_in),
    .req_in  (req_in),
`ifdef FIFO_PACK_FLUSH_EN
    .last_in (last_in),
`endif
    .ack_in  (ack_in),
    .d_out   (d_out),
    .cnt_out (cnt_out),
    .req_out (req_out),
    .ack_out (ack_out)
  );

  fifo_word_packer_chk #(.DW(DW), .N(N)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .req_in  (req_in),
    .ack_in  (ack_in),
    .d_out   (d_out),
    .cnt_out (cnt_out),
    .req_out (req_out),
    .ack_out (ack_out)
  );

  // Called at a falling edge; returns at a falling edge with reset released.
  task automatic apply_reset();
    rst = 1'b1; req_in = 1'b0; ack_out = 1'b0; d_in = '0;
`ifdef FIFO_PACK_FLUSH_EN
    last_in = 1'b0;
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] b);
    d_in = b; req_in = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    req_in = 1'b1; ack_out = 1'b1; d_in = 8'hFF;
    #2 rst = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (ack_in !== 1'b0) begin n_fail++; $display("FAIL reset_ack_in: got %b expected 0", ack_in); end
    n_checks++; if (req_out !== 1'b0) begin n_fail++; $display("FAIL reset_req_out: got %b expected 0", req_out); end
    n_checks++; if (d_out !== 32'h0) begin n_fail++; $display("FAIL reset_d_out: got %h expected 00000000", d_out); end
    n_checks++; if (cnt_out !== 3'd0) begin n_fail++; $display("FAIL reset_cnt_out: got %0d expected 0", cnt_out); end
    req_in = 1'b0; ack_out = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    logic exp_req;
    apply_reset();
    ack_out = 1'b1;
    send_beat(8'hEE);
    send_beat(8'hEF);
    req_in = 1'b0; rst = 1'b1; #1;
    n_checks++; if (req_out !== 1'b0) begin n_fail++; $display("FAIL midrst_req: got %b expected 0", req_out); end
    @(negedge clk);
    rst = 1'b0; ack_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d_in = 8'(8'h11 * (i + 1)); req_in = 1'b1;
      @(negedge clk);
      exp_req = (i == 3);
      n_checks++; if (req_out !== exp_req) begin n_fail++; $display("FAIL midrst_req_beat%0d: got %b expected %b", i, req_out, exp_req); end
    end
    req_in = 1'b0;
    n_checks++; if (d_out !== 32'h44332211) begin n_fail++; $display("FAIL midrst_word: got %h expected 44332211", d_out); end
    n_checks++; if (cnt_out !== 3'd4) begin n_fail++; $display("FAIL midrst_cnt: got %0d expected 4", cnt_out); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_words [3];
    logic        exp_req;
    exp_words = '{32'h03020100, 32'h07060504, 32'h0B0A0908};
    apply_reset();
    ack_out = 1'b1;
    for (int k = 0; k < 12; k++) begin
      d_in = 8'(k); req_in = 1'b1; #1;
      n_checks++; if (ack_in !== 1'b1) begin n_fail++; $display("FAIL stream_ack_in beat%0d: got %b expected 1", k, ack_in); end
      @(negedge clk);
      exp_req = ((k % 4) == 3);
      n_checks++; if (req_out !== exp_req) begin n_fail++; $display("FAIL stream_req beat%0d: got %b expected %b", k, req_out, exp_req); end
      if (exp_req) begin
        n_checks++; if (d_out !== exp_words[k/4]) begin n_fail++; $display("FAIL stream_word%0d: got %h expected %h", k/4, d_out, exp_words[k/4]); end
      end
    end
    req_in = 1'b0;
    @(negedge clk);
    n_checks++; if (req_out !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b expected 0", req_out); end
  endtask

  task automatic test_stall_and_simultaneous();
    apply_reset();
    ack_out = 1'b0;
    for (int i = 0; i < 7; i++) begin
      d_in = 8'hA0 + 8'(i); req_in = 1'b1; #1;
      n_checks++; if (ack_in !== 1'b1) begin n_fail++; $display("FAIL stall_ack_early beat%0d: got %b expected 1", i, ack_in); end
      @(negedge clk);
    end
    d_in = 8'hA7; #1;
    for (int c = 0; c < 2; c++) begin
      n_checks++; if (ack_in !== 1'b0) begin n_fail++; $display("FAIL stall_ack_block cyc%0d: got %b expected 0", c, ack_in); end
      n_checks++; if (d_out !== 32'hA3A2A1A0) begin n_fail++; $display("FAIL stall_hold cyc%0d: got %h expected a3a2a1a0", c, d_out); end
      n_checks++; if (cnt_out !== 3'd4) begin n_fail++; $display("FAIL stall_cnt cyc%0d: got %0d expected 4", c, cnt_out); end
      @(negedge clk); #1;
    end
    ack_out = 1'b1; #1;
    n_checks++; if (ack_in !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b expected 1", ack_in); end
    @(negedge clk);
    n_checks++; if (req_out !== 1'b1) begin n_fail++; $display("FAIL simul_req: got %b expected 1", req_out); end
    n_checks++; if (d_out !== 32'hA7A6A5A4) begin n_fail++; $display("FAIL simul_word: got %h expected a7a6a5a4", d_out); end
    req_in = 1'b0;
    @(negedge clk);
    n_checks++; if (req_out !== 1'b0) begin n_fail++; $display("FAIL simul_drain: got %b expected 0", req_out); end
    ack_out = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] macc;
    logic [7:0]  nxt;
    logic        hold;
    logic        exp_ack;
    logic        took;
    int          mcnt, beats, stalls, empties, cycles;
    macc = '0; nxt = 8'h00; mcnt = 0; beats = 0; stalls = 0; empties = 0; cycles = 0;
    apply_reset();
    while (beats < 200 && cycles < 5000) begin
      if (!req_in && ($urandom_range(0, 3) != 0)) begin
        req_in = 1'b1; d_in = nxt;
      end
      ack_out = ($urandom_range(0, 2) != 0);
      #1;
      hold    = (q.size() != 0);
      exp_ack = !((mcnt == 3) && hold && !ack_out);
      n_checks++; if (ack_in !== exp_ack) begin n_fail++; $display("FAIL rand_ack_in cyc%0d: got %b expected %b", cycles, ack_in, exp_ack); end
      n_checks++; if (req_out !== hold) begin n_fail++; $display("FAIL rand_req cyc%0d: got %b expected %b", cycles, req_out, hold); end
      if (hold && !ack_out) stalls++;
      if (!req_in) empties++;
      if (hold && ack_out) begin
        n_checks++; if (d_out !== q[0]) begin n_fail++; $display("FAIL rand_word cyc%0d: got %h expected %h", cycles, d_out, q[0]); end
        n_checks++; if (cnt_out !== 3'd4) begin n_fail++; $display("FAIL rand_cnt cyc%0d: got %0d expected 4", cycles, cnt_out); end
        void'(q.pop_front());
      end
      took = req_in && exp_ack;
      if (took) begin
        macc[mcnt*8 +: 8] = d_in;
        if (mcnt == 3) begin
          q.push_back(macc); macc = '0; mcnt = 0;
        end else begin
          mcnt++;
        end
        beats++; nxt++;
      end
      @(negedge clk);
      if (took) req_in = 1'b0;
      cycles++;
    end
    n_checks++; if (beats != 200) begin n_fail++; $display("FAIL rand_timeout: got %0d beats expected 200", beats); end
    req_in = 1'b0; ack_out = 1'b1;
    for (int j = 0; j < 4 && q.size() != 0; j++) begin
      #1;
      n_checks++; if (req_out !== 1'b1) begin n_fail++; $display("FAIL rand_drain_req: got %b expected 1", req_out); end
      n_checks++; if (d_out !== q[0]) begin n_fail++; $display("FAIL rand_drain_word: got %h expected %h", d_out, q[0]); end
      void'(q.pop_front());
      @(negedge clk);
    end
    #1;
    n_checks++; if (req_out !== 1'b0) begin n_fail++; $display("FAIL rand_final_req: got %b expected 0", req_out); end
    n_checks++; if (stalls < 5) begin n_fail++; $display("FAIL rand_stalls: got %0d expected >=5", stalls); end
    n_checks++; if (empties < 5) begin n_fail++; $display("FAIL rand_empties: got %0d expected >=5", empties); end
    ack_out = 1'b0;
    @(negedge clk);
  endtask

`ifdef FIFO_PACK_FLUSH_EN
  task automatic test_flush();
    apply_reset();
    ack_out = 1'b0;
    d_in = 8'h55; req_in = 1'b1; last_in = 1'b0;
    @(negedge clk);
    d_in = 8'h66; last_in = 1'b1;
    @(negedge clk);
    req_in = 1'b0; last_in = 1'b0;
    n_checks++; if (req_out !== 1'b1) begin n_fail++; $display("FAIL flush2_req: got %b expected 1", req_out); end
    n_checks++; if (d_out !== 32'h00006655) begin n_fail++; $display("FAIL flush2_word: got %h expected 00006655", d_out); end
    n_checks++; if (cnt_out !== 3'd2) begin n_fail++; $display("FAIL flush2_cnt: got %0d expected 2", cnt_out); end
    ack_out = 1'b1;
    @(negedge clk);
    n_checks++; if (req_out !== 1'b0) begin n_fail++; $display("FAIL flush2_drain: got %b expected 0", req_out); end
    d_in = 8'h77; req_in = 1'b1; last_in = 1'b1;
    @(negedge clk);
    req_in = 1'b0; last_in = 1'b0;
    n_checks++; if (d_out !== 32'h00000077) begin n_fail++; $display("FAIL flush1_word: got %h expected 00000077", d_out); end
    n_checks++; if (cnt_out !== 3'd1) begin n_fail++; $display("FAIL flush1_cnt: got %0d expected 1", cnt_out); end
    @(negedge clk);
    ack_out = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_word();
    test_streaming();
    test_stall_and_simultaneous();
    test_random();
`ifdef FIFO_PACK_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Sits directly downstream of the req/ack FIFO and consumes its DW-bit output stream.
- Packs N consecutive beats into one DW*N-bit word, then presents the word on a req/ack output port to the next stage, such as a bus write master.
- Both ports use the FIFO's protocol: a transfer occurs at a posedge where req & ack are both high.
- Buffers one complete word while assembling the next, so a stalled consumer does not stall the FIFO until the next word would complete.

Parameters:
- DW, 8, beat width in bits; matches the FIFO data width.
- N, 4, beats per packed word; must be ≥ 2.

Ports:
- clk  in  1  single clock; all logic is posedge.
- rst  in  1  asynchronous, active-high reset.
- d_in  in  DW  beat from the FIFO (the FIFO's d_out).
- req_in  in  1  beat valid (the FIFO's req_out).
- ack_in  out  1  beat accepted this cycle (drives the FIFO's ack_out).
- d_out  out  DW*N  packed word; lane i is d_out[i*DW +: DW].
- cnt_out  out  $clog2(N+1)  number of valid lanes in d_out.
- req_out  out  1  packed word valid.
- ack_out  in  1  consumer accepts the word.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Internal state:
  - accumulator acc[DW*N-1:0] and lane counter cnt (0..N-1);
  - output holding register, driving d_out, cnt_out and req_out.
- Reset values: req_out=0, d_out=0, cnt_out=0, cnt=0, acc=0.
  - ack_in=0 while rst is high.
  - Reset asserted mid-word discards any partial word and any held word, with no output transfer.
- Packing order: the first beat of a word goes to lane 0 (LSBs); beat k goes to lane k.
- closing = (cnt==N-1), or (last_in when FIFO_PACK_FLUSH_EN is defined).
- ack_in = ~rst & (~closing | ~req_out | ack_out). This is combinational from ack_out and cnt.
  - Non-closing beats are always accepted, even while the output word waits.
- On accept of a non-closing beat: write lane cnt, then cnt++.
- On accept of a closing beat:
  - next cycle: d_out = acc with lane cnt replaced by d_in; lanes above cnt are zero.
  - cnt_out = cnt+1; req_out=1; cnt=0; acc=0.
- Latency: req_out rises exactly 1 cycle after the closing beat is accepted.
- Output hold: while req_out=1 and ack_out=0, d_out and cnt_out are stable and req_out stays high.
- Output transfer (req_out & ack_out):
  - if a closing beat is accepted in the same cycle, the new word loads and req_out stays 1, giving back-to-back words;
  - otherwise req_out=0 next cycle, and d_out keeps its last value (don't care).
- Sustained throughput with ack_out=1 and req_in=1: 1 beat/cycle, 1 word per N cycles, no bubbles.
- Stall boundary: closing beat pending, req_out=1, ack_out=0 → ack_in=0. The FIFO holds its beat with no data loss or duplication.
- Counter wrap: cnt returns to 0 after every closing beat and never reaches N.

Optional Feature:
- Macro: FIFO_PACK_FLUSH_EN.
- Defined:
  - adds port last_in, input, 1 bit, qualified by req_in.
  - An accepted beat with last_in=1 closes the word early; cnt_out = lanes filled (1..N) and unused upper lanes = 0.
  - last_in on lane N-1 behaves as a normal closing beat.
- Undefined:
  - no last_in port.
  - Only full words are emitted; cnt_out is N whenever req_out=1.

Decomposition:
- Package fifo_pack_pkg:
  - default DW/N localparams;
  - CW = $clog2(N+1) cnt width function;
  - lane-index typedef.
- Single module; the output holding register is inline and is not worth a sub-module. The reset-value constants are shared with the FIFO bench.

Test Plan:
- Reset mid-word: after 2 beats, pulse rst → no req_out; next beats 0x11,0x22,0x33,0x44 → d_out=0x44332211, cnt_out=4.
- Streaming, ack_out=1, req_in=1: beats 0x00..0x0B → words 0x03020100, 0x07060504, 0x0B0A0908 on consecutive 4-cycle boundaries, with no gaps in ack_in.
- Output stall, ack_out=0: beats 0xA0..0xA6 accepted, then ack_in=0 on the 8th beat. Raise ack_out → 0xA3A2A1A0 transfers, 0xA7 is accepted the same cycle, and the next word is 0xA7A6A5A4.
- Random req_in/ack_out with the FIFO upstream, 200 beats against a scoreboard queue → every word matches; at least 5 stall cycles and at least 5 empty cycles are observed.
- FIFO_PACK_FLUSH_EN: beats 0x55,0x66 with last_in on 0x66 → d_out=0x00006655, cnt_out=2. Then a single beat 0x77 with last_in → d_out=0x00000077, cnt_out=1.
- Simultaneous event: closing beat accepted in the same cycle as the output ack → req_out stays 1 and d_out changes to the new word on the next edge.
